// File: rtl/conv_pkg.sv
// conv_pkg: FSM state type and size helpers shared by conv_engine and conv_mac.
// Contents: state_t (IDLE/RUN/HOLD/DONE), calc_m (output side), calc_accw (accumulator width), bits (counter width, min 1).
package conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  function automatic int calc_m(input int n, input int k);
    return n - k + 1;
  endfunction
  function automatic int calc_accw(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction
  function automatic int bits(input int v);
    return v < 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered signed multiply-accumulate with clear and enable.
// Ports: clk, rst (sync, active-high), clr (zero acc), en (acc += a*b), a/b (signed DW), acc (signed ACCW).
module conv_mac #(
  parameter int DW = 8,
  parameter int ACCW = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*DW-1:0] p;
  assign p = a * b;
  always_ff @(posedge clk)
    acc <= (rst || clr) ? '0 : en ? acc + ACCW'(p) : acc;
endmodule

// File: rtl/conv_engine.sv
// conv_engine: sequential KxK valid convolution over an NxN signed image, one MAC per cycle.
// Ports: clk, rst (sync, active-high); wr_en/wr_sel/wr_addr/wr_data load image (sel=0) or kernel (sel=1) while idle;
// start begins a run; busy covers RUN/HOLD/DONE; out_valid/out_ready/out_data/out_idx hand out one result per window;
// done pulses once after the last result is accepted.
// Build option: define CONV_ENGINE_RELU_EN to clamp negative results to zero.
module conv_engine
  import conv_pkg::*;
#(
  parameter int DW = 8,
  parameter int N = 4,
  parameter int K = 3,
  localparam int M = calc_m(N, K),
  localparam int ACCW = calc_accw(DW, K)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [$clog2(N*N)-1:0]       wr_addr,
  input  logic signed [DW-1:0]         wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACCW-1:0]       out_data,
  output logic [$clog2(M*M)-1:0]       out_idx,
  output logic                         done
);
  localparam int KK = K * K;
  localparam int MM = M * M;
  localparam int AW = $clog2(N * N);
  localparam int KAW = bits(KK);
  localparam int KW = bits(K);
  localparam int MW = bits(M);
  localparam int TW = bits(KK + 1);
  localparam int IW = $clog2(MM);
  if (K > N) begin : g_bad_k
    $error("conv_engine: K must not exceed N");
  end
  state_t state, nxt;
  logic signed [DW-1:0] img [N*N];
  logic signed [DW-1:0] ker [KK];
  logic signed [DW-1:0] pix, wgt;
  logic signed [ACCW-1:0] acc, res;
  logic [MW-1:0] wrow, wcol;
  logic [IW-1:0] widx;
  logic [KW-1:0] ti, tj;
  logic [TW-1:0] tc;
  logic term_end, win_last, hs, go;
  int ia, ka;
  assign term_end = tc == TW'(KK);
  assign win_last = widx == IW'(MM - 1);
  assign go = state == IDLE && start;
  assign hs = state == HOLD && out_ready;
  assign busy = state != IDLE;
  assign out_valid = state == HOLD;
  assign done = state == DONE;
  // Storage is deliberately outside reset so a run can be repeated without reloading.
  always_ff @(posedge clk)
    if (!rst && state == IDLE && wr_en)
      if (wr_sel) begin
        if (int'(wr_addr) < KK) ker[wr_addr[KAW-1:0]] <= wr_data;
      end else if (int'(wr_addr) < N * N) img[wr_addr] <= wr_data;
  // On the final RUN cycle ti steps past K-1; the fetched operands are unused since the MAC is disabled.
  always_comb begin
    ia = (int'(wrow) + int'(ti)) * N + int'(wcol) + int'(tj);
    ka = int'(ti) * K + int'(tj);
    pix = img[ia[AW-1:0]];
    wgt = ker[ka[KAW-1:0]];
  end
`ifdef CONV_ENGINE_RELU_EN
  assign res = acc[ACCW-1] ? '0 : acc;
`else
  assign res = acc;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RUN : IDLE;
      RUN:     nxt = term_end ? HOLD : RUN;
      HOLD:    nxt = out_ready ? (win_last ? DONE : RUN) : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_ff @(posedge clk)
    if (rst) begin
      out_data <= '0;
      out_idx <= '0;
    end else if (state == RUN && term_end) begin
      out_data <= res;
      out_idx <= widx;
    end
  // RUN spends K*K cycles accumulating and one more cycle (term_end) registering the result.
  always_ff @(posedge clk)
    if (rst || go || hs) begin
      tc <= '0;
      ti <= '0;
      tj <= '0;
    end else if (state == RUN && !term_end) begin
      tc <= tc + 1'b1;
      tj <= tj == KW'(K - 1) ? '0 : tj + 1'b1;
      ti <= tj == KW'(K - 1) ? ti + 1'b1 : ti;
    end
  always_ff @(posedge clk)
    if (rst || go || (hs && win_last)) begin
      wrow <= '0;
      wcol <= '0;
      widx <= '0;
    end else if (hs) begin
      widx <= widx + 1'b1;
      wcol <= wcol == MW'(M - 1) ? '0 : wcol + 1'b1;
      wrow <= wcol == MW'(M - 1) ? wrow + 1'b1 : wrow;
    end
  conv_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(go || hs),
    .en(state == RUN && !term_end),
    .a(pix),
    .b(wgt),
    .acc(acc)
  );
endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter DW, default 8, signed bit width of image pixels and kernel weights.
REQ-002 Parameter N, default 4, image side length (image is NxN).
REQ-003 Parameter K, default 3, kernel side length (kernel is KxK); K<=N, otherwise elaboration SHALL fail.
REQ-004 Derived constants: M=N-K+1 (output side), ACCW=2*DW+$clog2(K*K) (accumulator width).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wr_en  in  1  load strobe for image/kernel storage.
REQ-008 wr_sel  in  1  0 = image store, 1 = kernel store.
REQ-009 wr_addr  in  $clog2(N*N)  row-major element index; kernel uses indices 0..K*K-1 only.
REQ-010 wr_data  in  DW  signed element value.
REQ-011 start  in  1  one-cycle request to begin convolution.
REQ-012 busy  out  1  high from accepted start until done pulse.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result when out_valid && out_ready.
REQ-015 out_data  out  ACCW  signed result of current output window.
REQ-016 out_idx  out  $clog2(M*M)  row-major index of current result.
REQ-017 done  out  1  one-cycle pulse after final result accepted.

Function
REQ-018 FSM states IDLE, RUN, HOLD, DONE; IDLE->RUN on start; RUN->HOLD after K*K MAC cycles of a window; HOLD->RUN on handshake if windows remain, HOLD->DONE on handshake of last window; DONE->IDLE unconditionally after one cycle.
REQ-019 Writes take effect only in IDLE; wr_en in any other state is ignored; writes to kernel addresses >=K*K are ignored.
REQ-020 start is accepted only in IDLE; start outside IDLE is ignored; wr_en and start in same IDLE cycle: write completes and start is accepted.
REQ-021 Window order row-major over (r,c) in 0..M-1; within a window, terms (i,j) row-major, one MAC per cycle: acc += img[r+i][c+j]*ker[i][j], signed, full ACCW precision, no overflow possible.
REQ-022 Accumulator clears at start of each window; out_data/out_idx register on RUN->HOLD; out_valid high exactly in HOLD.
REQ-023 First out_valid asserts K*K+1 cycles after the clock edge sampling start; each later window follows K*K+1 cycles after previous handshake.
REQ-024 While out_valid && !out_ready, out_data and out_idx SHALL hold stable.
REQ-025 busy is high in RUN, HOLD and DONE; done is high only in DONE.

Reset
REQ-026 rst forces IDLE, busy=0, out_valid=0, done=0, out_data=0, out_idx=0, accumulator and window/term counters=0, including mid-operation; rst has priority over all inputs.
REQ-027 Image and kernel storage are not cleared by rst; contents persist.

Configuration
REQ-028 Macro CONV_ENGINE_RELU_EN defined: result negative registers out_data=0 (ReLU); undefined: signed result passes unmodified.

Structure
REQ-029 Shared package conv_pkg holds FSM state typedef and ACCW/M derivation functions.
REQ-030 Sub-module conv_mac: registered signed multiply-accumulate with clear and enable, width parameters DW/ACCW.

Verification
REQ-031 N=4,K=3, image all 1, kernel all 1, start, out_ready=1 -> four results of 9, idx 0..3, first out_valid 10 cycles after start edge, done once.
REQ-032 Image pixel p=row*4+col, kernel center 1 others 0 -> results 5,6,9,10.
REQ-033 Image all -128, kernel all 127, macro undefined -> each result -146304; macro defined -> each result 0.
REQ-034 out_ready held low 5 cycles on idx 1 -> out_data/out_idx stable, no result lost or duplicated.
REQ-035 rst asserted during RUN of idx 2 -> next cycle IDLE, outputs 0; restart without reload -> same four results.
REQ-036 start and wr_en pulsed while busy -> ignored; results unchanged; single done.
